pb_event_arbiter: RTL and testbench

Multi-button input controller for the miniRISC FPGA board. It synchronises and debounces `NUM_PB` raw push buttons using one shared sample-tick divider. Each clean press becomes a pending event. A round-robin arbiter hands events one at a time, over a valid/ready handshake, to the processor's input/step logic. This replaces per-button clock dividers and keeps the whole block in the single system clock domain.

---
 rtl/pb_event_arbiter_pkg.sv | 14 +
 rtl/pb_event_arbiter_if.sv | 24 ++
 rtl/pb_event_arbiter_filter.sv | 45 ++++
 rtl/pb_event_arbiter.sv | 125 ++++++++++++
 tb/tb_pb_event_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pb_event_arbiter_pkg.sv
// Shared definitions for the push-button event arbiter: arbiter state encoding
// and tick divider presets for the 50 MHz board and for fast simulation.
package pb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_PRESENT = 1'b1
    } arb_state_t;

    // 250000 cycles at 50 MHz gives a 5 ms sample tick
    localparam int TICK_DIV_BOARD = 250000;
    localparam int TICK_DIV_SIM   = 4;

endpackage

// File: rtl/pb_event_arbiter_if.sv
// Valid/ready event channel from the button arbiter to the processor step logic.
// The drop pulse travels alongside so the consumer can count lost presses.
interface pb_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            ev_valid;
    logic [ID_W-1:0] ev_id;
    logic            ev_ready;
    logic            ev_drop;

    modport master (
        output ev_valid,
        output ev_id,
        output ev_drop,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_id,
        input  ev_drop,
        output ev_ready
    );
endinterface

// File: rtl/pb_event_arbiter_filter.sv
// One button: two-flop synchroniser, tick-driven stable counter, debounced
// level register and a registered one-cycle press pulse on each 0->1 change.
module pb_filter #(
    parameter int STABLE_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pb_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(STABLE_TICKS);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // The counter only advances while the synchronised input disagrees with the level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pb_in};
            press  <= 1'b0;
            if (tick) begin
                if (sync_q[1] != level) begin
                    if (int'(cnt) + 1 == STABLE_TICKS) begin
                        level <= ~level;
                        cnt   <= '0;
                        press <= ~level;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/pb_event_arbiter.sv
// Debounces NUM_PB buttons on a shared sample tick, latches each clean press as
// a pending event and hands events out round-robin over a valid/ready channel.
module pb_event_arbiter
    import pb_pkg::*;
#(
    parameter int NUM_PB       = 4,
    parameter int TICK_DIV     = TICK_DIV_BOARD,
    parameter int STABLE_TICKS = 4,
    parameter int ID_W         = $clog2(NUM_PB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_PB-1:0] pb_in,
    output logic [NUM_PB-1:0] pb_level,
    pb_event_arbiter_if.master ev
);

    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick;
    logic [NUM_PB-1:0] press;
    logic [NUM_PB-1:0] pending;
    logic [NUM_PB-1:0] clr;
    logic              drop_q;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   id_next;
    logic [ID_W-1:0]   last;
    logic [ID_W-1:0]   last_next;
    logic [ID_W-1:0]   sel;
    logic              found;
    int                idx;

    assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_filter
        pb_filter #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_filter (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .pb_in(pb_in[i]),
            .level(pb_level[i]),
            .press(press[i])
        );
    end

    // A press landing on its own accept cycle re-arms the bit, so set beats clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            drop_q  <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | press;
            drop_q  <= |(press & pending & ~clr);
        end
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_PB; k++) begin
            idx = (int'(last) + k) % NUM_PB;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            id_q  <= '0;
            last  <= ID_W'(NUM_PB - 1);
        end else begin
            state <= state_next;
            id_q  <= id_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        id_next    = id_q;
        last_next  = last;
        clr        = '0;
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    id_next    = sel;
                    state_next = ARB_PRESENT;
                end
            end
            ARB_PRESENT: begin
                if (ev.ev_ready) begin
                    clr[id_q]  = 1'b1;
                    last_next  = id_q;
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign ev.ev_valid = (state == ARB_PRESENT);
    assign ev.ev_id    = id_q;
    assign ev.ev_drop  = drop_q;

endmodule

// File: tb/tb_pb_event_arbiter.sv
// Self-checking bench for pb_event_arbiter: a per-cycle vector table for the
// clean press, then directed sequences for glitch, ordering, drop and reset.
module tb_pb_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pb_in;
    logic [3:0] pb_level;

    int n_compared   = 0;
    int n_mismatched = 0;

    pb_event_arbiter_if #(.ID_W(2)) ev_bus ();

    pb_event_arbiter #(
        .NUM_PB      (4),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .ID_W        (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pb_in   (pb_in),
        .pb_level(pb_level),
        .ev      (ev_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] pb;
        logic       rdy;
        logic [3:0] exp_level;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic       exp_drop;
    } vec_t;

    vec_t vecs[23];
    int   ids[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic [3:0] pb, input logic rdy);
        rst_n           = r;
        pb_in           = pb;
        ev_bus.ev_ready = rdy;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_level(input logic [3:0] want, input int max_cycles, input string name);
        int n = 0;
        while (pb_level != want && n < max_cycles) begin
            step();
            n++;
        end
        check_output(name, pb_level, want);
    endtask

    task automatic wait_valid(input int max_cycles, input string name);
        int n = 0;
        while (!ev_bus.ev_valid && n < max_cycles) begin
            step();
            n++;
        end
        check_output(name, ev_bus.ev_valid, 1);
    endtask

    task automatic collect_events(input int cycles);
        ids.delete();
        for (int c = 0; c < cycles; c++) begin
            step();
            if (ev_bus.ev_valid) ids.push_back(int'(ev_bus.ev_id));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        int drops;
        int accepts;
        int seen_level;
        int seen_valid;

        apply_stimulus(1'b0, 4'b0000, 1'b0);

        // Edge 0 after reset release: level rises at edge 11 (3rd tick), event at 13
        for (int r = 0; r < 2; r++) vecs[r] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        for (int e = 0; e <= 20; e++)
            vecs[e + 2] = '{1'b1, 4'b0100, 1'b1, (e >= 11) ? 4'b0100 : 4'b0000, (e == 13), 2'd2, 1'b0};

        for (int r = 0; r < 23; r++) begin
            apply_stimulus(vecs[r].rst_n, vecs[r].pb, vecs[r].rdy);
            step();
            check_output($sformatf("vec%0d_level", r), pb_level, vecs[r].exp_level);
            check_output($sformatf("vec%0d_valid", r), ev_bus.ev_valid, vecs[r].exp_valid);
            check_output($sformatf("vec%0d_drop", r), ev_bus.ev_drop, vecs[r].exp_drop);
            if (vecs[r].exp_valid)
                check_output($sformatf("vec%0d_id", r), ev_bus.ev_id, vecs[r].exp_id);
        end

        seen_valid = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ev_bus.ev_valid) seen_valid++;
        end
        check_output("held_no_repeat", seen_valid, 0);

        apply_stimulus(1'b1, 4'b0000, 1'b1);
        wait_level(4'b0000, 40, "release2_level");
        apply_stimulus(1'b1, 4'b0010, 1'b1);
        repeat (6) step();
        apply_stimulus(1'b1, 4'b0000, 1'b1);
        seen_level = 0;
        seen_valid = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (pb_level[1]) seen_level++;
            if (ev_bus.ev_valid) seen_valid++;
        end
        check_output("glitch_level", seen_level, 0);
        check_output("glitch_valid", seen_valid, 0);

        apply_stimulus(1'b0, 4'b0000, 1'b1);
        step();
        apply_stimulus(1'b1, 4'b1011, 1'b1);
        collect_events(80);
        check_output("rr_count", ids.size(), 3);
        if (ids.size() == 3) begin
            check_output("rr_first", ids[0], 0);
            check_output("rr_second", ids[1], 1);
            check_output("rr_third", ids[2], 3);
        end

        apply_stimulus(1'b1, 4'b0000, 1'b1);
        wait_level(4'b0000, 40, "rr_release_level");
        apply_stimulus(1'b1, 4'b1001, 1'b1);
        collect_events(60);
        check_output("rr2_count", ids.size(), 2);
        if (ids.size() == 2) begin
            check_output("rr2_first", ids[0], 0);
            check_output("rr2_second", ids[1], 3);
        end

        apply_stimulus(1'b1, 4'b0000, 1'b0);
        wait_level(4'b0000, 40, "bp_pre_release_level");
        apply_stimulus(1'b1, 4'b0010, 1'b0);
        wait_valid(60, "bp_valid");
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!ev_bus.ev_valid || ev_bus.ev_id != 2'd1) bad++;
        end
        check_output("bp_hold_bad_cycles", bad, 0);

        drops = 0;
        apply_stimulus(1'b1, 4'b0000, 1'b0);
        for (int c = 0; c < 40 && pb_level != 4'b0000; c++) begin
            step();
            if (ev_bus.ev_drop) drops++;
        end
        check_output("bp_release_level", pb_level, 0);
        apply_stimulus(1'b1, 4'b0010, 1'b0);
        for (int c = 0; c < 30; c++) begin
            step();
            if (ev_bus.ev_drop) drops++;
        end
        check_output("bp_repress_level", pb_level, 4'b0010);
        check_output("bp_drop_pulses", drops, 1);
        check_output("bp_still_valid", ev_bus.ev_valid, 1);
        check_output("bp_still_id", ev_bus.ev_id, 1);

        apply_stimulus(1'b1, 4'b0010, 1'b1);
        accepts = 0;
        for (int c = 0; c < 20; c++) begin
            if (ev_bus.ev_valid) accepts++;
            step();
        end
        check_output("bp_accepts", accepts, 1);

        apply_stimulus(1'b1, 4'b0000, 1'b0);
        wait_level(4'b0000, 40, "rst_pre_release_level");
        apply_stimulus(1'b1, 4'b0100, 1'b0);
        wait_valid(60, "rst_pre_valid");
        apply_stimulus(1'b0, 4'b0000, 1'b0);
        step();
        check_output("rst_level", pb_level, 0);
        check_output("rst_valid", ev_bus.ev_valid, 0);
        check_output("rst_id", ev_bus.ev_id, 0);
        check_output("rst_drop", ev_bus.ev_drop, 0);
        apply_stimulus(1'b1, 4'b1000, 1'b1);
        wait_valid(60, "post_rst_valid");
        check_output("post_rst_id", ev_bus.ev_id, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
